la_acq: RTL and testbench



---
 rtl/la_acq_if.sv | 23 ++
 rtl/la_acq.sv | 195 +++++++++++++++++++
 tb/tb_la_acq.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/la_acq_if.sv
// Sample stream bundle for la_acq: the digital-input side (sti_*) and the
// capture-buffer side (sto_*). The controller uses the slave modport.
interface la_acq_if #(
   parameter int DW = 16
);
   logic [DW-1:0] sti_dat;
   logic          sti_vld;
   logic          sti_rdy;
   logic [DW-1:0] sto_dat;
   logic          sto_vld;
   logic          sto_lst;
   logic          sto_rdy;

   modport slave (
      input  sti_dat, sti_vld, sto_rdy,
      output sti_rdy, sto_dat, sto_vld, sto_lst
   );

   modport master (
      output sti_dat, sti_vld, sto_rdy,
      input  sti_rdy, sto_dat, sto_vld, sto_lst
   );
endinterface

// File: rtl/la_acq.sv
// Logic-analyzer acquisition controller: pre-trigger / armed / post-trigger
// windowing of the sample stream. Optional automatic mode: LA_ACQ_AUTO_EN.
module la_acq #(
   parameter int DW = 16,
   parameter int CW = 32,
   parameter int TN = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ctl_rst,
   input  logic          ctl_acq,
   input  logic          ctl_stp,
   input  logic [TN-1:0] cfg_trg,
   input  logic [CW-1:0] cfg_pre,
   input  logic [CW-1:0] cfg_pst,
   input  logic          cfg_aut,
   input  logic [TN-1:0] trg_i,
   output logic          trg_o,
   output logic          sts_acq,
   output logic          sts_trg,
   output logic [CW-1:0] sts_pre,
   output logic [CW-1:0] sts_pst,
   la_acq_if.slave       strm
);

   typedef enum logic [1:0] {IDLE, PRE, ARM, POST} state_t;

   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] pre_lat;
   logic [CW-1:0] pst_lat;
   logic [CW-1:0] pre_sum;
   logic [CW-1:0] pst_sum;
   logic          acc;
   logic          trig;
   logic          auto_go;
   logic          start;
   logic          stop;
   logic          fire;
   logic          last;
   logic          pre_inc;
   logic          pst_inc;

`ifdef LA_ACQ_AUTO_EN
   assign auto_go = cfg_aut;
`else
   logic unused_aut;
   assign unused_aut = cfg_aut;
   assign auto_go    = 1'b0;
`endif

   // Samples offered while idle are swallowed so the sampler never stalls.
   assign strm.sti_rdy = (state == IDLE) ? 1'b1 : (~strm.sto_vld | strm.sto_rdy);
   assign acc          = strm.sti_vld & strm.sti_rdy & (state != IDLE);
   assign trig         = (|(trg_i & cfg_trg)) | auto_go;
   assign pre_sum      = (sts_pre == {CW{1'b1}}) ? sts_pre : sts_pre + ONE;
   assign pst_sum      = sts_pst + ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // In automatic mode the window jumps straight to POST at the point it
   // would have armed, so the run spans exactly pre + post samples.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      stop       = 1'b0;
      fire       = 1'b0;
      last       = 1'b0;
      pre_inc    = 1'b0;
      pst_inc    = 1'b0;
      if (ctl_rst) begin
         state_next = IDLE;
      end else if (ctl_stp) begin
         if (state != IDLE) begin
            stop       = 1'b1;
            state_next = IDLE;
         end
      end else begin
         case (state)
            IDLE: begin
               if (ctl_acq) begin
                  start = 1'b1;
                  if (cfg_pre != '0) begin
                     state_next = PRE;
                  end else if (auto_go) begin
                     fire       = 1'b1;
                     state_next = POST;
                  end else begin
                     state_next = ARM;
                  end
               end
            end
            PRE: begin
               if (acc) begin
                  pre_inc = 1'b1;
                  if (pre_sum == pre_lat) begin
                     if (auto_go) begin
                        fire       = 1'b1;
                        state_next = POST;
                     end else begin
                        state_next = ARM;
                     end
                  end
               end
            end
            ARM: begin
               pre_inc = acc;
               if (trig) begin
                  fire       = 1'b1;
                  state_next = POST;
               end
            end
            POST: begin
               if (acc) begin
                  pst_inc = 1'b1;
                  if (pst_sum == pst_lat) begin
                     last       = 1'b1;
                     state_next = IDLE;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Status, latched configuration and the single-entry output register.
   // A stop tags whatever sample ends up held so the writer sees a closed run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_lat      <= '0;
         pst_lat      <= '0;
         sts_pre      <= '0;
         sts_pst      <= '0;
         sts_trg      <= 1'b0;
         sts_acq      <= 1'b0;
         trg_o        <= 1'b0;
         strm.sto_dat <= {DW{1'b0}};
         strm.sto_vld <= 1'b0;
         strm.sto_lst <= 1'b0;
      end else if (ctl_rst) begin
         pre_lat      <= '0;
         pst_lat      <= '0;
         sts_pre      <= '0;
         sts_pst      <= '0;
         sts_trg      <= 1'b0;
         sts_acq      <= 1'b0;
         trg_o        <= 1'b0;
         strm.sto_dat <= {DW{1'b0}};
         strm.sto_vld <= 1'b0;
         strm.sto_lst <= 1'b0;
      end else begin
         trg_o <= fire;
         if (start) begin
            pre_lat <= cfg_pre;
            pst_lat <= (cfg_pst == '0) ? ONE : cfg_pst;
            sts_pre <= '0;
            sts_pst <= '0;
            sts_trg <= 1'b0;
            sts_acq <= 1'b1;
         end
         if (stop || last) begin
            sts_acq <= 1'b0;
         end
         if (pre_inc) begin
            sts_pre <= pre_sum;
         end
         if (pst_inc) begin
            sts_pst <= pst_sum;
         end
         if (fire) begin
            sts_trg <= 1'b1;
         end
         if (acc) begin
            strm.sto_dat <= strm.sti_dat;
            strm.sto_vld <= 1'b1;
            strm.sto_lst <= last | stop;
         end else if (stop && strm.sto_vld && !strm.sto_rdy) begin
            strm.sto_lst <= 1'b1;
         end else if (strm.sto_rdy) begin
            strm.sto_vld <= 1'b0;
            strm.sto_lst <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_la_acq.sv
// Directed self-checking bench for la_acq; the automatic-mode run is only
// built when LA_ACQ_AUTO_EN is defined.
module tb_la_acq;

   localparam int DW = 16;
   localparam int CW = 32;
   localparam int TN = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ctl_rst;
   logic          ctl_acq;
   logic          ctl_stp;
   logic [TN-1:0] cfg_trg;
   logic [CW-1:0] cfg_pre;
   logic [CW-1:0] cfg_pst;
   logic          cfg_aut;
   logic [TN-1:0] trg_i;
   logic          trg_o;
   logic          sts_acq;
   logic          sts_trg;
   logic [CW-1:0] sts_pre;
   logic [CW-1:0] sts_pst;

   la_acq_if #(.DW(DW)) bus ();

   la_acq #(.DW(DW), .CW(CW), .TN(TN)) dut (
      .clk     (clk),
      .rst     (rst),
      .ctl_rst (ctl_rst),
      .ctl_acq (ctl_acq),
      .ctl_stp (ctl_stp),
      .cfg_trg (cfg_trg),
      .cfg_pre (cfg_pre),
      .cfg_pst (cfg_pst),
      .cfg_aut (cfg_aut),
      .trg_i   (trg_i),
      .trg_o   (trg_o),
      .sts_acq (sts_acq),
      .sts_trg (sts_trg),
      .sts_pre (sts_pre),
      .sts_pst (sts_pst),
      .strm    (bus)
   );

   always #5 clk = ~clk;

   int            checks;
   int            errors;
   int            trgCount;
   int            tc;
   int            i0;
   logic          inAcc;
   bit            stallPrev;
   logic [DW-1:0] heldDat;
   logic          heldLst;
   logic [DW-1:0] outDat[$];
   logic          outLst[$];

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Inputs are already driven; observe at the falling edge, return at posedge+1.
   task automatic cycleOnce();
      @(negedge clk);
      if (stallPrev) begin
         checkOutput("hold_vld", bus.sto_vld, 1'b1);
         checkOutput("hold_dat", bus.sto_dat, heldDat);
         checkOutput("hold_lst", bus.sto_lst, heldLst);
      end
      stallPrev = bus.sto_vld && !bus.sto_rdy;
      heldDat   = bus.sto_dat;
      heldLst   = bus.sto_lst;
      if (trg_o) trgCount++;
      if (bus.sto_vld && bus.sto_rdy) begin
         outDat.push_back(bus.sto_dat);
         outLst.push_back(bus.sto_lst);
      end
      inAcc = bus.sti_vld && bus.sti_rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic a);
      ctl_rst = r;
      ctl_stp = s;
      ctl_acq = a;
      cycleOnce();
      ctl_rst = 1'b0;
      ctl_stp = 1'b0;
      ctl_acq = 1'b0;
   endtask

   task automatic sendSample(input logic [DW-1:0] dat, input logic [TN-1:0] trg);
      bus.sti_vld = 1'b1;
      bus.sti_dat = dat;
      trg_i       = trg;
      cycleOnce();
      bus.sti_vld = 1'b0;
      trg_i       = '0;
   endtask

   // Streams nSend counting samples and fires trg_i[1] in the cycle the
   // sample with index trigAt is accepted.
   task automatic runCapture(input int nSend, input int trigAt, input bit randRdy,
                             input logic [DW-1:0] base);
      int sent;
      int cyc;
      int idx0;
      int n;
      int dataErr;
      int lstErr;
      logic [DW-1:0] expDat;
      sent = 0;
      cyc  = 0;
      idx0 = outDat.size();
      while ((sent < nSend || bus.sto_vld) && cyc < 500) begin
         bus.sto_rdy = randRdy ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.sti_vld = (sent < nSend);
         bus.sti_dat = base + DW'(sent);
         #1;
         trg_i = (sent == trigAt && bus.sti_vld && bus.sti_rdy) ? 4'b0010 : 4'b0000;
         cycleOnce();
         if (inAcc) sent++;
         cyc++;
      end
      bus.sti_vld = 1'b0;
      bus.sto_rdy = 1'b1;
      trg_i       = '0;
      checkOutput("cap_sent", sent, nSend);
      n = outDat.size() - idx0;
      checkOutput("cap_count", n, nSend);
      dataErr = 0;
      lstErr  = 0;
      for (int i = 0; i < n; i++) begin
         expDat = base + DW'(i);
         if (outDat[idx0 + i] !== expDat) dataErr++;
         if (outLst[idx0 + i] !== (i == nSend - 1)) lstErr++;
      end
      checkOutput("cap_data", dataErr, 0);
      checkOutput("cap_lst", lstErr, 0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      trgCount  = 0;
      stallPrev = 1'b0;
      heldDat   = '0;
      heldLst   = 1'b0;
      inAcc     = 1'b0;
      rst       = 1'b1;
      ctl_rst   = 1'b0;
      ctl_acq   = 1'b0;
      ctl_stp   = 1'b0;
      cfg_trg   = '0;
      cfg_pre   = '0;
      cfg_pst   = '0;
      cfg_aut   = 1'b0;
      trg_i     = '0;
      bus.sti_dat = '0;
      bus.sti_vld = 1'b0;
      bus.sto_rdy = 1'b1;

      #3;
      checkOutput("rst_sto_vld", bus.sto_vld, 1'b0);
      checkOutput("rst_sts_acq", sts_acq, 1'b0);
      checkOutput("rst_sti_rdy", bus.sti_rdy, 1'b1);
      checkOutput("rst_sts_pre", sts_pre, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // normal capture
      cfg_pre = 32'd8;
      cfg_pst = 32'd16;
      cfg_trg = 4'b0010;
      tc = trgCount;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("acq_rise", sts_acq, 1'b1);
      runCapture(36, 19, 1'b0, 16'h1000);
      checkOutput("norm_pre", sts_pre, 32'd20);
      checkOutput("norm_pst", sts_pst, 32'd16);
      checkOutput("norm_trg", sts_trg, 1'b1);
      checkOutput("norm_acq", sts_acq, 1'b0);
      checkOutput("norm_trg_o", trgCount - tc, 1);

      // backpressure
      tc = trgCount;
      applyStimulus(1'b0, 1'b0, 1'b1);
      runCapture(36, 19, 1'b1, 16'h2000);
      checkOutput("bp_pre", sts_pre, 32'd20);
      checkOutput("bp_pst", sts_pst, 32'd16);
      checkOutput("bp_acq", sts_acq, 1'b0);
      checkOutput("bp_trg_o", trgCount - tc, 1);

      // early, coincident and masked triggers
      cfg_pre = 32'd4;
      cfg_pst = 32'd2;
      tc = trgCount;
      applyStimulus(1'b0, 1'b0, 1'b1);
      sendSample(16'h3000, 4'b0010);
      sendSample(16'h3001, 4'b0010);
      sendSample(16'h3002, 4'b0000);
      sendSample(16'h3003, 4'b0010);
      checkOutput("early_pre", sts_pre, 32'd4);
      checkOutput("early_trg", sts_trg, 1'b0);
      trg_i = 4'b0001;
      cycleOnce();
      cycleOnce();
      cycleOnce();
      trg_i = 4'b0000;
      checkOutput("mask_trg", sts_trg, 1'b0);
      checkOutput("mask_trg_o", trgCount - tc, 0);
      trg_i = 4'b0010;
      cycleOnce();
      trg_i = 4'b0000;
      cycleOnce();
      checkOutput("arm_trg_o", trgCount - tc, 1);
      checkOutput("arm_trg", sts_trg, 1'b1);
      checkOutput("arm_pre", sts_pre, 32'd4);
      sendSample(16'h3004, 4'b0000);
      sendSample(16'h3005, 4'b0000);
      cycleOnce();
      checkOutput("short_dat", outDat[$], 16'h3005);
      checkOutput("short_lst", outLst[$], 1'b1);
      checkOutput("short_pst", sts_pst, 32'd2);
      checkOutput("short_acq", sts_acq, 1'b0);

      // stop with a stalled sample
      cfg_pre = 32'd2;
      cfg_pst = 32'd16;
      applyStimulus(1'b0, 1'b0, 1'b1);
      sendSample(16'h4000, 4'b0000);
      sendSample(16'h4001, 4'b0000);
      bus.sto_rdy = 1'b0;
      cycleOnce();
      applyStimulus(1'b0, 1'b1, 1'b0);
      stallPrev = 1'b0;
      checkOutput("stp_vld", bus.sto_vld, 1'b1);
      checkOutput("stp_dat", bus.sto_dat, 16'h4001);
      checkOutput("stp_lst", bus.sto_lst, 1'b1);
      checkOutput("stp_acq", sts_acq, 1'b0);
      bus.sto_rdy = 1'b1;
      cycleOnce();
      checkOutput("stp_out_dat", outDat[$], 16'h4001);
      checkOutput("stp_out_lst", outLst[$], 1'b1);
      sendSample(16'h4abc, 4'b0000);
      checkOutput("stp_idle", bus.sto_vld, 1'b0);
      checkOutput("stp_pre", sts_pre, 32'd2);

      // soft reset beats acquire
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("crst_acq", sts_acq, 1'b0);
      checkOutput("crst_pre", sts_pre, 32'd0);
      sendSample(16'h4def, 4'b0000);
      checkOutput("crst_idle", bus.sto_vld, 1'b0);

      // asynchronous reset in POST with a held sample
      cfg_pre = 32'd0;
      cfg_pst = 32'd8;
      applyStimulus(1'b0, 1'b0, 1'b1);
      sendSample(16'h5000, 4'b0010);
      checkOutput("post_vld", bus.sto_vld, 1'b1);
      checkOutput("post_trg_o", trg_o, 1'b1);
      bus.sto_rdy = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_vld", bus.sto_vld, 1'b0);
      checkOutput("arst_dat", bus.sto_dat, 16'h0000);
      checkOutput("arst_lst", bus.sto_lst, 1'b0);
      checkOutput("arst_trg_o", trg_o, 1'b0);
      checkOutput("arst_acq", sts_acq, 1'b0);
      checkOutput("arst_trg", sts_trg, 1'b0);
      checkOutput("arst_pre", sts_pre, 32'd0);
      checkOutput("arst_pst", sts_pst, 32'd0);
      checkOutput("arst_rdy", bus.sti_rdy, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.sto_rdy = 1'b1;
      stallPrev = 1'b0;

`ifdef LA_ACQ_AUTO_EN
      cfg_aut = 1'b1;
      cfg_pre = 32'd0;
      cfg_pst = 32'd4;
      cfg_trg = 4'b0000;
      tc = trgCount;
      i0 = outDat.size();
      applyStimulus(1'b0, 1'b0, 1'b1);
      sendSample(16'h6000, 4'b0000);
      sendSample(16'h6001, 4'b0000);
      sendSample(16'h6002, 4'b0000);
      sendSample(16'h6003, 4'b0000);
      cycleOnce();
      checkOutput("auto_count", outDat.size() - i0, 4);
      checkOutput("auto_dat", outDat[$], 16'h6003);
      checkOutput("auto_lst", outLst[$], 1'b1);
      checkOutput("auto_trg", sts_trg, 1'b1);
      checkOutput("auto_pst", sts_pst, 32'd4);
      checkOutput("auto_acq", sts_acq, 1'b0);
      checkOutput("auto_trg_o", trgCount - tc, 1);
      cfg_aut = 1'b0;
`else
      i0 = outDat.size();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
